// File: rtl/btn_pkg.sv
// Shared encodings and timing constants for the push-button conditioning path.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } btn_state_t;

  // 10 ms of settling time at the 50 MHz system clock.
  localparam int unsigned DEBOUNCE_10MS_50MHZ = 500000;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser, 2-cycle latency, sync reset to 0; no flow control.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/btn_debounce_toggle.sv
// Synchronise + debounce BTNC, emit press/release pulses and a press-toggled updown level.
// Outputs move STABLE_CYCLES+1 edges after the raw level settles; no backpressure, all outputs registered.
module btn_debounce_toggle
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter logic        INIT_UPDOWN   = 1'b1
) (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic updown
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic btn_s2;

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             updown_q, updown_d;

  sync_2ff u_sync (
    .clk   (clk_50MHz),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_s2)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    updown_d = updown_q;
    case (state_q)
      ST_RELEASED: begin
        if (btn_s2) begin
          state_d = ST_WAIT_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_WAIT_PRESS: begin
        // A drop back to 0 is a bounce: abandon the press silently.
        if (!btn_s2) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_PRESSED;
          cnt_d    = '0;
          press_d  = 1'b1;
          level_d  = 1'b1;
          updown_d = ~updown_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!btn_s2) begin
          state_d = ST_WAIT_RELEASE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ST_WAIT_RELEASE: begin
        if (btn_s2) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
          rel_d   = 1'b1;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q  <= ST_RELEASED;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      updown_q <= INIT_UPDOWN;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      updown_q <= updown_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;
  assign updown      = updown_q;

endmodule

// File: tb/tb_btn_debounce_toggle.sv
// Directed bench for btn_debounce_toggle with STABLE_CYCLES=4 (press/release land 5 edges after the raw change).
module tb_btn_debounce_toggle;

  logic clk_50MHz = 1'b0;
  logic reset     = 1'b1;
  logic btn_raw   = 1'b0;
  logic btn_level, btn_press, btn_release, updown;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int press_cnt = 0, release_cnt = 0, both_cnt = 0;
  int last_press_cyc = -1, last_release_cyc = -1;

  btn_debounce_toggle #(
    .STABLE_CYCLES (4),
    .INIT_UPDOWN   (1'b1)
  ) dut (
    .clk_50MHz   (clk_50MHz),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .updown      (updown)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  always @(posedge clk_50MHz) cyc = cyc + 1;

  // Pulse bookkeeping, sampled mid-cycle; cyc is the index of the most recent rising edge.
  always @(negedge clk_50MHz) begin
    if (btn_press === 1'b1) begin
      press_cnt = press_cnt + 1;
      last_press_cyc = cyc;
    end
    if (btn_release === 1'b1) begin
      release_cnt = release_cnt + 1;
      last_release_cyc = cyc;
    end
    if (btn_press === 1'b1 && btn_release === 1'b1) both_cnt = both_cnt + 1;
  end

  task automatic tick();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic test_reset();
    int p0;
    reset = 1'b1;
    btn_raw = 1'b1;
    repeat (3) tick();
    n_checks++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL reset_level got=%b exp=0", btn_level); end
    n_checks++; if (btn_press !== 1'b0) begin n_fail++; $display("FAIL reset_press got=%b exp=0", btn_press); end
    n_checks++; if (btn_release !== 1'b0) begin n_fail++; $display("FAIL reset_release got=%b exp=0", btn_release); end
    n_checks++; if (updown !== 1'b1) begin n_fail++; $display("FAIL reset_updown got=%b exp=1", updown); end
    p0 = press_cnt + release_cnt;
    reset = 1'b0;
    btn_raw = 1'b0;
    tick();
    n_checks++; if (btn_press !== 1'b0 || btn_release !== 1'b0) begin n_fail++; $display("FAIL post_reset_pulse press=%b release=%b exp=0/0", btn_press, btn_release); end
    repeat (8) tick();
    n_checks++; if (press_cnt + release_cnt != p0) begin n_fail++; $display("FAIL post_reset_idle pulses=%0d exp=0", press_cnt + release_cnt - p0); end
  endtask

  task automatic test_press();
    int e0;
    int p0;
    p0 = press_cnt;
    e0 = cyc + 1;
    btn_raw = 1'b1;
    while (cyc < e0 + 4) tick();
    n_checks++; if (btn_press !== 1'b0 || btn_level !== 1'b0) begin n_fail++; $display("FAIL press_early press=%b level=%b exp=0/0", btn_press, btn_level); end
    tick();
    n_checks++; if (btn_press !== 1'b1) begin n_fail++; $display("FAIL press_pulse got=%b exp=1 at E0+5", btn_press); end
    n_checks++; if (btn_level !== 1'b1) begin n_fail++; $display("FAIL press_level got=%b exp=1", btn_level); end
    n_checks++; if (updown !== 1'b0) begin n_fail++; $display("FAIL press_updown got=%b exp=0", updown); end
    tick();
    n_checks++; if (btn_press !== 1'b0) begin n_fail++; $display("FAIL press_width got=%b exp=0", btn_press); end
    n_checks++; if (press_cnt - p0 != 1 || last_press_cyc != e0 + 5) begin n_fail++; $display("FAIL press_timing count=%0d exp=1 edge=%0d exp=%0d", press_cnt - p0, last_press_cyc, e0 + 5); end
  endtask

  task automatic test_held();
    int e0;
    int p0, r0;
    p0 = press_cnt;
    r0 = release_cnt;
    repeat (100) tick();
    n_checks++; if (press_cnt != p0) begin n_fail++; $display("FAIL held_repeat extra_presses=%0d exp=0", press_cnt - p0); end
    n_checks++; if (btn_level !== 1'b1 || updown !== 1'b0) begin n_fail++; $display("FAIL held_state level=%b updown=%b exp=1/0", btn_level, updown); end
    e0 = cyc + 1;
    btn_raw = 1'b0;
    while (cyc < e0 + 4) tick();
    n_checks++; if (btn_release !== 1'b0 || btn_level !== 1'b1) begin n_fail++; $display("FAIL release_early release=%b level=%b exp=0/1", btn_release, btn_level); end
    tick();
    n_checks++; if (btn_release !== 1'b1 || btn_level !== 1'b0) begin n_fail++; $display("FAIL release_pulse release=%b level=%b exp=1/0", btn_release, btn_level); end
    n_checks++; if (updown !== 1'b0) begin n_fail++; $display("FAIL release_updown got=%b exp=0", updown); end
    tick();
    n_checks++; if (btn_release !== 1'b0) begin n_fail++; $display("FAIL release_width got=%b exp=0", btn_release); end
    n_checks++; if (release_cnt - r0 != 1 || last_release_cyc != e0 + 5) begin n_fail++; $display("FAIL release_timing count=%0d exp=1 edge=%0d exp=%0d", release_cnt - r0, last_release_cyc, e0 + 5); end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    int p0;
    pat = 6'b110110;
    p0 = press_cnt;
    for (int i = 5; i >= 0; i--) begin
      btn_raw = pat[i];
      tick();
    end
    btn_raw = 1'b0;
    repeat (10) tick();
    n_checks++; if (press_cnt != p0) begin n_fail++; $display("FAIL bounce_press got=%0d exp=0", press_cnt - p0); end
    n_checks++; if (btn_level !== 1'b0 || updown !== 1'b0) begin n_fail++; $display("FAIL bounce_state level=%b updown=%b exp=0/0", btn_level, updown); end
  endtask

  task automatic test_back_to_back();
    int p0, r0, b0;
    logic exp_ud;
    reset = 1'b1;
    btn_raw = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    n_checks++; if (updown !== 1'b1) begin n_fail++; $display("FAIL b2b_reset_updown got=%b exp=1", updown); end
    p0 = press_cnt;
    r0 = release_cnt;
    b0 = both_cnt;
    exp_ud = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_ud = ~exp_ud;
      btn_raw = 1'b1;
      repeat (8) tick();
      n_checks++; if (updown !== exp_ud || btn_level !== 1'b1) begin n_fail++; $display("FAIL b2b_press%0d updown=%b exp=%b level=%b exp=1", i, updown, exp_ud, btn_level); end
      btn_raw = 1'b0;
      repeat (8) tick();
      n_checks++; if (updown !== exp_ud || btn_level !== 1'b0) begin n_fail++; $display("FAIL b2b_release%0d updown=%b exp=%b level=%b exp=0", i, updown, exp_ud, btn_level); end
    end
    n_checks++; if (press_cnt - p0 != 3 || release_cnt - r0 != 3) begin n_fail++; $display("FAIL b2b_counts press=%0d release=%0d exp=3/3", press_cnt - p0, release_cnt - r0); end
    n_checks++; if (both_cnt != b0) begin n_fail++; $display("FAIL b2b_coincident got=%0d exp=0", both_cnt - b0); end
  endtask

  task automatic test_reset_mid();
    int e0, r1;
    int p0;
    p0 = press_cnt;
    e0 = cyc + 1;
    btn_raw = 1'b1;
    // After E0+3 the counter holds 2 in WAIT_PRESS.
    while (cyc < e0 + 3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    r1 = cyc + 1;
    n_checks++; if (btn_press !== 1'b0 || btn_level !== 1'b0 || updown !== 1'b1) begin n_fail++; $display("FAIL midreset_state press=%b level=%b updown=%b exp=0/0/1", btn_press, btn_level, updown); end
    while (cyc < r1 + 4) tick();
    n_checks++; if (press_cnt != p0 || btn_level !== 1'b0) begin n_fail++; $display("FAIL midreset_early presses=%0d level=%b exp=0/0", press_cnt - p0, btn_level); end
    tick();
    n_checks++; if (btn_press !== 1'b1 || updown !== 1'b0) begin n_fail++; $display("FAIL midreset_fresh press=%b updown=%b exp=1/0", btn_press, updown); end
    tick();
    n_checks++; if (press_cnt - p0 != 1) begin n_fail++; $display("FAIL midreset_count got=%0d exp=1", press_cnt - p0); end
    btn_raw = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    test_reset();
    test_press();
    test_held();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL never_coincident got=%0d exp=0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
